// File: rtl/serial_adder_seq.sv
// Bit-serial WIDTH-bit adder: one full-adder cell and one carry flop, LSB first.
// The operands are taken on an in_valid/in_ready handshake and the result is returned on an out_valid/out_ready handshake.

module serial_adder_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);
  assign s_o  = a_i ^ b_i ^ c_i;
  assign co_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module serial_adder_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             fa_s, fa_co;
  logic [WIDTH-1:0] sum_shift;
  logic             last_bit;

  serial_adder_fa u_fa (
    .a_i  (a_sh_q[0]),
    .b_i  (b_sh_q[0]),
    .c_i  (carry_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at LSB.
  generate
    if (WIDTH == 1) begin : g_w1
      assign sum_shift = fa_s;
    end else begin : g_wn
      assign sum_shift = {fa_s, sum_sh_q[WIDTH-1:1]};
    end
  endgenerate

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_sh_d   = a;
          b_sh_d   = b;
          carry_d  = cin;
          cnt_d    = '0;
          sum_sh_d = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = sum_shift;
        carry_d  = fa_co;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_bit) begin
          // Signed overflow: carry into the MSB differs from carry out of it.
          ovf_d   = carry_q ^ fa_co;
          sum_d   = sum_shift;
          cout_d  = fa_co;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  // Handshake outputs are pure state decodes, so no input-to-output path exists.
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Scoreboard bench for serial_adder_seq at WIDTH=8, 1 and 16 against an arithmetic reference model.
module tb_serial_adder_seq;

  typedef struct packed {
    logic [63:0] s;
    logic        c;
    logic        o;
  } res_t;

  logic gclk = 1'b0;
  always #5 gclk = ~gclk;
  logic rst_n;

  logic       iv8, ir8, ov8, or8, cin8, co8, ovf8;
  logic [7:0] a8, b8, s8;
  logic       iv1, ir1, ov1, or1, cin1, co1, ovf1;
  logic [0:0] a1, b1, s1;
  logic        iv16, ir16, ov16, or16, cin16, co16, ovf16;
  logic [15:0] a16, b16, s16;

  int total = 0;
  int bad   = 0;
  res_t q8[$], q1[$], q16[$];

  serial_adder_seq #(.WIDTH(8)) u_w8 (
    .clk(gclk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(cin8),
    .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .ovf(ovf8));
  serial_adder_seq #(.WIDTH(1)) u_w1 (
    .clk(gclk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(cin1),
    .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1), .ovf(ovf1));
  serial_adder_seq #(.WIDTH(16)) u_w16 (
    .clk(gclk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .cin(cin16),
    .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16), .ovf(ovf16));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Reference: plain unsigned add for sum/cout, true signed range test for overflow.
  function automatic res_t ref_add(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic c);
    res_t r;
    logic [64:0] full;
    longint lim, sa, sb, ss;
    full = {1'b0, a} + {1'b0, b} + 65'(c);
    r.s  = full[63:0] & ((64'd1 << w) - 64'd1);
    r.c  = full[w];
    lim  = longint'(1) << (w - 1);
    sa   = a[w-1] ? longint'(a) - (lim << 1) : longint'(a);
    sb   = b[w-1] ? longint'(b) - (lim << 1) : longint'(b);
    ss   = sa + sb + longint'(c);
    r.o  = (ss >= lim) || (ss < -lim);
    return r;
  endfunction

  task automatic pop_cmp(input string tag, inout res_t q[$], input logic [63:0] s,
                         input logic c, input logic o);
    res_t e;
    if (q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s_unexpected_output sum=%0h", tag, s);
    end else begin
      e = q.pop_front();
      chk({tag, "_sum"}, s, e.s);
      chk({tag, "_cout"}, 64'(c), 64'(e.c));
      chk({tag, "_ovf"}, 64'(o), 64'(e.o));
    end
  endtask

  always @(negedge gclk) if (rst_n && ov8 && or8)   pop_cmp("w8", q8, 64'(s8), co8, ovf8);
  always @(negedge gclk) if (rst_n && ov1 && or1)   pop_cmp("w1", q1, 64'(s1), co1, ovf1);
  always @(negedge gclk) if (rst_n && ov16 && or16) pop_cmp("w16", q16, 64'(s16), co16, ovf16);

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input int hold, input bit toggle);
    res_t e;
    int lat;
    e = ref_add(8, 64'(a), 64'(b), c);
    @(negedge gclk);
    chk("w8_in_ready_idle", 64'(ir8), 64'd1);
    a8 = a; b8 = b; cin8 = c; iv8 = 1'b1; or8 = (hold == 0);
    q8.push_back(e);
    @(posedge gclk); #1;
    iv8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < 40) begin
      if (toggle) begin
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); iv8 = 1'($urandom);
      end
      @(posedge gclk); #1;
      lat++;
    end
    iv8 = 1'b0;
    chk("w8_latency", 64'(lat), 64'd8);
    for (int i = 0; i < hold; i++) begin
      @(negedge gclk);
      chk("w8_hold_valid", 64'(ov8), 64'd1);
      chk("w8_hold_in_ready", 64'(ir8), 64'd0);
      chk("w8_hold_sum", 64'(s8), e.s);
      chk("w8_hold_cout_ovf", 64'({co8, ovf8}), 64'({e.c, e.o}));
    end
    if (hold > 0) begin
      @(posedge gclk); #1;
      or8 = 1'b1;
    end
    @(posedge gclk); #1;
    chk("w8_back_to_idle", 64'({ov8, ir8}), 64'b01);
  endtask

  task automatic run1(input logic a, input logic b, input logic c);
    int lat;
    @(negedge gclk);
    a1 = a; b1 = b; cin1 = c; iv1 = 1'b1;
    q1.push_back(ref_add(1, 64'(a), 64'(b), c));
    @(posedge gclk); #1;
    iv1 = 1'b0;
    lat = 0;
    while (!ov1 && lat < 20) begin
      @(posedge gclk); #1;
      lat++;
    end
    chk("w1_latency", 64'(lat), 64'd1);
    @(posedge gclk); #1;
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic c, input int hold);
    int lat;
    @(negedge gclk);
    a16 = a; b16 = b; cin16 = c; iv16 = 1'b1; or16 = 1'b0;
    q16.push_back(ref_add(16, 64'(a), 64'(b), c));
    @(posedge gclk); #1;
    iv16 = 1'b0;
    lat = 0;
    while (!ov16 && lat < 60) begin
      @(posedge gclk); #1;
      lat++;
    end
    if (lat != 16) chk("w16_latency", 64'(lat), 64'd16);
    repeat (hold) @(posedge gclk);
    #1 or16 = 1'b1;
    @(posedge gclk); #1;
    or16 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    iv8 = 0; a8 = 0; b8 = 0; cin8 = 0; or8 = 1;
    iv1 = 0; a1 = 0; b1 = 0; cin1 = 0; or1 = 1;
    iv16 = 0; a16 = 0; b16 = 0; cin16 = 0; or16 = 0;
    #12;
    chk("reset_w8_ready_valid", 64'({ir8, ov8}), 64'b10);
    chk("reset_w8_outs", 64'({s8, co8, ovf8}), 64'd0);
    @(negedge gclk) rst_n = 1'b1;

    run8(8'h0F, 8'h01, 1'b0, 0, 0);
    run8(8'hFF, 8'h01, 1'b0, 0, 0);
    run8(8'hFF, 8'h00, 1'b1, 0, 0);
    run8(8'h80, 8'h80, 1'b0, 0, 0);
    run8(8'hA5, 8'h3C, 1'b1, 5, 1);
    run8(8'h7F, 8'h01, 1'b0, 0, 0);

    // Abort in the middle of RUN: outputs must clear before the next edge.
    @(negedge gclk);
    a8 = 8'h55; b8 = 8'h66; cin8 = 1'b1; iv8 = 1'b1;
    @(posedge gclk); #1;
    iv8 = 1'b0;
    repeat (3) @(posedge gclk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ready_valid", 64'({ir8, ov8}), 64'b10);
    chk("abort_outs", 64'({s8, co8, ovf8}), 64'd0);
    @(negedge gclk) rst_n = 1'b1;
    run8(8'h12, 8'h34, 1'b0, 0, 0);

    run1(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) run1(1'($urandom), 1'($urandom), 1'($urandom));

    for (int i = 0; i < 1000; i++)
      run16(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

    repeat (3) @(posedge gclk);
    chk("q8_drained", 64'(q8.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    chk("q16_drained", 64'(q16.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
